alu_req_sched: RTL and testbench

- Two-requester scheduler that shares one ALU_DESIGN instance.
- Round-robin arbitration between the requesters, one operation in flight at a time.
- Presents both operands together (INP_VALID=11) and holds ALU inputs for the command-dependent latency.
- Captures RES and flags, cleans z/x to 0, and returns a tagged response over a valid/ready handshake. Sits between the bus-side command queues and the ALU.

---
 rtl/alu_req_sched_if.sv | 79 +++++++
 rtl/alu_req_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_req_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_sched_if.sv
// ----------------------------------------------------------------------------
// alu_req_sched_if : request, ALU-side and response signals of alu_req_sched
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_req_sched_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  // requester 0
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_opa;
  logic [DW-1:0] req0_opb;
  logic [CW-1:0] req0_cmd;
  logic          req0_mode;
  logic          req0_cin;

  // requester 1
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_opa;
  logic [DW-1:0] req1_opb;
  logic [CW-1:0] req1_cmd;
  logic          req1_mode;
  logic          req1_cin;

  // ALU drive side
  logic          alu_ce;
  logic [1:0]    alu_inp_valid;
  logic [DW-1:0] alu_opa;
  logic [DW-1:0] alu_opb;
  logic [CW-1:0] alu_cmd;
  logic          alu_mode;
  logic          alu_cin;

  // ALU result side; nets because the ALU may leave flags floating
  wire  [DW+1:0] alu_res;
  wire           alu_cout;
  wire           alu_oflow;
  wire           alu_g;
  wire           alu_e;
  wire           alu_l;
  wire           alu_err;

  // response
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW+1:0] rsp_res;
  logic [5:0]    rsp_flags;
  logic          rsp_illegal;

  modport slave (
    input  req0_valid, req0_opa, req0_opb, req0_cmd, req0_mode, req0_cin,
    output req0_ready,
    input  req1_valid, req1_opa, req1_opb, req1_cmd, req1_mode, req1_cin,
    output req1_ready,
    output alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin,
    input  alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
    output rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_opa, req0_opb, req0_cmd, req0_mode, req0_cin,
    input  req0_ready,
    output req1_valid, req1_opa, req1_opb, req1_cmd, req1_mode, req1_cin,
    input  req1_ready,
    input  alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin,
    output alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_illegal,
    output rsp_ready
  );

endinterface

`default_nettype wire

// File: rtl/alu_req_sched.sv
// ----------------------------------------------------------------------------
// alu_req_sched : round-robin two-requester scheduler in front of one ALU
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module alu_req_sched #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT_STD = 2,
  parameter int LAT_MUL = 3
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  alu_req_sched_if.slave   bus
);

  localparam int c_LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
  localparam int c_CNT_W   = $clog2(c_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_last;
  logic                r_id;
  logic                r_mul;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                r_alu_ce;
  logic [1:0]          r_alu_inp_valid;
  logic [DW-1:0]       r_alu_opa;
  logic [DW-1:0]       r_alu_opb;
  logic [CW-1:0]       r_alu_cmd;
  logic                r_alu_mode;
  logic                r_alu_cin;

  logic [DW+1:0]       r_rsp_res;
  logic [5:0]          r_rsp_flags;
  logic                r_rsp_illegal;

  logic                w_any;
  logic                w_gid;
  logic [DW-1:0]       w_sel_opa;
  logic [DW-1:0]       w_sel_opb;
  logic [CW-1:0]       w_sel_cmd;
  logic                w_sel_mode;
  logic                w_sel_cin;
  logic                w_legal;
  logic                w_mul;
  logic                w_last_wait;
  logic [DW+1:0]       w_res_clean;
  logic [5:0]          w_flags_raw;
  logic [5:0]          w_flags_clean;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_any = 1'b0;
    w_gid = 1'b0;
    if (r_state == IDLE) begin
      w_any = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
        w_gid = ~r_last;
      end else begin
        w_gid = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = w_any & ~w_gid;
  assign bus.req1_ready = w_any &  w_gid;

  always_comb begin
    w_sel_opa  = w_gid ? bus.req1_opa  : bus.req0_opa;
    w_sel_opb  = w_gid ? bus.req1_opb  : bus.req0_opb;
    w_sel_cmd  = w_gid ? bus.req1_cmd  : bus.req0_cmd;
    w_sel_mode = w_gid ? bus.req1_mode : bus.req0_mode;
    w_sel_cin  = w_gid ? bus.req1_cin  : bus.req0_cin;
    w_legal    = w_sel_mode ? (w_sel_cmd <= CW'(10)) : (w_sel_cmd <= CW'(13));
    w_mul      = w_sel_mode && ((w_sel_cmd == CW'(9)) || (w_sel_cmd == CW'(10)));
  end

  assign w_last_wait = (r_cnt == c_CNT_W'(1));

  // Anything that is not a solid 1 (0, z, x) is captured as 0.
  always_comb begin
    w_res_clean = '0;
    for (int i = 0; i < DW + 2; i++) begin
      if (bus.alu_res[i] == 1'b1) begin
        w_res_clean[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_flags_raw   = {bus.alu_err, bus.alu_l, bus.alu_e, bus.alu_g, bus.alu_oflow, bus.alu_cout};
    w_flags_clean = '0;
    for (int i = 0; i < 6; i++) begin
      if (w_flags_raw[i] == 1'b1) begin
        w_flags_clean[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = w_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (w_last_wait) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ALU inputs are loaded on the accept edge so they are already valid in ISSUE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last          <= 1'b1;
      r_id            <= 1'b0;
      r_mul           <= 1'b0;
      r_cnt           <= '0;
      r_alu_ce        <= 1'b0;
      r_alu_inp_valid <= 2'b00;
      r_alu_opa       <= '0;
      r_alu_opb       <= '0;
      r_alu_cmd       <= '0;
      r_alu_mode      <= 1'b0;
      r_alu_cin       <= 1'b0;
      r_rsp_res       <= '0;
      r_rsp_flags     <= '0;
      r_rsp_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last <= w_gid;
            r_id   <= w_gid;
            if (w_legal) begin
              r_mul           <= w_mul;
              r_alu_ce        <= 1'b1;
              r_alu_inp_valid <= 2'b11;
              r_alu_opa       <= w_sel_opa;
              r_alu_opb       <= w_sel_opb;
              r_alu_cmd       <= w_sel_cmd;
              r_alu_mode      <= w_sel_mode;
              r_alu_cin       <= w_sel_cin;
            end else begin
              r_rsp_illegal <= 1'b1;
              r_rsp_res     <= '0;
              r_rsp_flags   <= '0;
            end
          end
        end
        ISSUE: begin
          r_cnt <= r_mul ? c_CNT_W'(LAT_MUL) : c_CNT_W'(LAT_STD);
        end
        WAIT: begin
          if (w_last_wait) begin
            r_alu_ce        <= 1'b0;
            r_alu_inp_valid <= 2'b00;
            r_rsp_res       <= w_res_clean;
            r_rsp_flags     <= w_flags_clean;
            r_rsp_illegal   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.alu_ce        = r_alu_ce;
  assign bus.alu_inp_valid = r_alu_inp_valid;
  assign bus.alu_opa       = r_alu_opa;
  assign bus.alu_opb       = r_alu_opb;
  assign bus.alu_cmd       = r_alu_cmd;
  assign bus.alu_mode      = r_alu_mode;
  assign bus.alu_cin       = r_alu_cin;

  assign bus.rsp_valid     = (r_state == RESP);
  assign bus.rsp_id        = r_id;
  assign bus.rsp_res       = r_rsp_res;
  assign bus.rsp_flags     = r_rsp_flags;
  assign bus.rsp_illegal   = r_rsp_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_sched.sv
// ----------------------------------------------------------------------------
// tb_alu_req_sched : directed bench with a small pipelined ALU model
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_req_sched;

  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_req_sched_if #(.DW(DW), .CW(CW)) bus ();

  alu_req_sched #(.DW(DW), .CW(CW), .LAT_STD(2), .LAT_MUL(3)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALU model: one register stage, multiplies (mode 1, cmd 9/10) take two.
  logic [9:0] mc_res;
  logic [5:0] mc_fl;
  logic       mc_zr;
  logic [5:0] mc_zf;
  logic       mc_mul;
  logic [9:0] s_res = 10'h3FF;
  logic [5:0] s_fl  = 6'h3F;
  logic       s_zr  = 1'b0;
  logic [5:0] s_zf  = 6'h00;
  logic [9:0] m_res = '0;
  logic [5:0] m_fl  = '0;
  logic       m_zr  = 1'b0;
  logic [5:0] m_zf  = '0;

  always_comb begin
    mc_res = '0;
    mc_fl  = '0;
    mc_zr  = 1'b0;
    mc_zf  = 6'h00;
    mc_mul = bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10);
    if (bus.alu_mode) begin
      case (bus.alu_cmd)
        4'd0: begin
          mc_res = {2'b00, bus.alu_opa} + {2'b00, bus.alu_opb};
          mc_fl  = {5'b0, mc_res[8]};
          mc_zf  = 6'b111110;
        end
        4'd8: begin
          mc_zr = 1'b1;
          mc_fl = {1'b0, bus.alu_opa < bus.alu_opb, bus.alu_opa == bus.alu_opb,
                   bus.alu_opa > bus.alu_opb, 2'b00};
          mc_zf = 6'b100011;
        end
        4'd9: begin
          mc_res = ({2'b00, bus.alu_opa} + 10'd1) * ({2'b00, bus.alu_opb} + 10'd1);
          mc_zf  = 6'h3F;
        end
        default: begin
        end
      endcase
    end else if (bus.alu_cmd == 4'd0) begin
      mc_res = {2'b00, bus.alu_opa & bus.alu_opb};
      mc_zf  = 6'h3F;
    end
  end

  always @(posedge clk) begin
    if (bus.alu_ce && bus.alu_inp_valid == 2'b11) begin
      if (mc_mul) begin
        m_res <= s_res; m_fl <= s_fl; m_zr <= s_zr; m_zf <= s_zf;
        s_res <= mc_res; s_fl <= mc_fl; s_zr <= mc_zr; s_zf <= mc_zf;
      end else begin
        m_res <= mc_res; m_fl <= mc_fl; m_zr <= mc_zr; m_zf <= mc_zf;
      end
    end else begin
      s_res <= 10'h3FF; s_fl <= 6'h3F; s_zr <= 1'b0; s_zf <= 6'h00;
    end
  end

  assign bus.alu_res   = m_zr     ? {10{1'bz}} : m_res;
  assign bus.alu_cout  = m_zf[0]  ? 1'bz : m_fl[0];
  assign bus.alu_oflow = m_zf[1]  ? 1'bz : m_fl[1];
  assign bus.alu_g     = m_zf[2]  ? 1'bz : m_fl[2];
  assign bus.alu_e     = m_zf[3]  ? 1'bz : m_fl[3];
  assign bus.alu_l     = m_zf[4]  ? 1'bz : m_fl[4];
  assign bus.alu_err   = m_zf[5]  ? 1'bz : m_fl[5];

  // Results of the last run_op, compared by the calling test.
  logic       o_rdy;
  int         o_lat;
  int         o_ce;
  logic       o_hold;
  logic       o_id;
  logic [9:0] o_res;
  logic [5:0] o_fl;
  logic       o_ill;

  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] c, input logic m, input logic ci);
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_opa = a; bus.req1_opb = b;
      bus.req1_cmd = c; bus.req1_mode = m; bus.req1_cin = ci;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_opa = a; bus.req0_opb = b;
      bus.req0_cmd = c; bus.req0_mode = m; bus.req0_cin = ci;
    end
    #1 o_rdy = id ? bus.req1_ready : bus.req0_ready;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    o_lat  = 1;
    o_ce   = 0;
    o_hold = 1'b1;
    while (bus.rsp_valid !== 1'b1 && o_lat < 20) begin
      if (bus.alu_ce === 1'b1) begin
        o_ce++;
        if (bus.alu_opa !== a || bus.alu_opb !== b || bus.alu_cmd !== c ||
            bus.alu_mode !== m || bus.alu_cin !== ci || bus.alu_inp_valid !== 2'b11)
          o_hold = 1'b0;
      end
      @(negedge clk);
      o_lat++;
    end
    o_id  = bus.rsp_id;
    o_res = bus.rsp_res;
    o_fl  = bus.rsp_flags;
    o_ill = bus.rsp_illegal;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_id: got %b want 0", bus.rsp_id); end
    n_cmp++; if (bus.rsp_res !== 10'd0 || bus.rsp_flags !== 6'd0 || bus.rsp_illegal !== 1'b0) begin
      n_bad++; $display("FAIL rst_rsp_data: got res=%h flags=%b ill=%b want 0/0/0", bus.rsp_res, bus.rsp_flags, bus.rsp_illegal); end
    n_cmp++; if ({bus.alu_ce, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin} !== 25'd0) begin
      n_bad++; $display("FAIL rst_alu_outputs: got ce=%b iv=%b opa=%h opb=%h cmd=%h want all 0", bus.alu_ce, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd); end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    run_op(1'b0, 8'd200, 8'd100, 4'd0, 1'b1, 1'b0);
    n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", o_rdy); end
    n_cmp++; if (o_lat !== 4) begin n_bad++; $display("FAIL add_latency: got %0d want 4", o_lat); end
    n_cmp++; if (o_ce !== 3 || o_hold !== 1'b1) begin n_bad++; $display("FAIL add_alu_drive: got ce_cycles=%0d hold=%b want 3/1", o_ce, o_hold); end
    n_cmp++; if (o_res !== 10'd300) begin n_bad++; $display("FAIL add_res: got %0d want 300", o_res); end
    n_cmp++; if (o_fl !== 6'b000001) begin n_bad++; $display("FAIL add_flags: got %b want 000001", o_fl); end
    n_cmp++; if (o_id !== 1'b0 || o_ill !== 1'b0) begin n_bad++; $display("FAIL add_id_illegal: got id=%b ill=%b want 0/0", o_id, o_ill); end
  endtask

  task automatic test_mul_latency();
    run_op(1'b1, 8'd3, 8'd4, 4'd9, 1'b1, 1'b0);
    n_cmp++; if (o_lat !== 5) begin n_bad++; $display("FAIL mul_latency: got %0d want 5", o_lat); end
    n_cmp++; if (o_ce !== 4 || o_hold !== 1'b1) begin n_bad++; $display("FAIL mul_alu_drive: got ce_cycles=%0d hold=%b want 4/1", o_ce, o_hold); end
    n_cmp++; if (o_res !== 10'd20) begin n_bad++; $display("FAIL mul_res: got %0d want 20", o_res); end
    n_cmp++; if (o_id !== 1'b1 || o_fl !== 6'd0) begin n_bad++; $display("FAIL mul_id_flags: got id=%b flags=%b want 1/000000", o_id, o_fl); end
  endtask

  task automatic test_illegal();
    run_op(1'b0, 8'd7, 8'd7, 4'hF, 1'b1, 1'b0);
    n_cmp++; if (o_ce !== 0) begin n_bad++; $display("FAIL ill_no_ce: got %0d ce cycles want 0", o_ce); end
    n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL ill_latency: got %0d want 1", o_lat); end
    n_cmp++; if (o_ill !== 1'b1) begin n_bad++; $display("FAIL ill_flag: got %b want 1", o_ill); end
    n_cmp++; if (o_res !== 10'd0 || o_fl !== 6'd0) begin n_bad++; $display("FAIL ill_payload: got res=%0d flags=%b want 0/000000", o_res, o_fl); end
  endtask

  task automatic test_compare_zflags();
    run_op(1'b0, 8'd5, 8'd9, 4'd8, 1'b1, 1'b0);
    n_cmp++; if (o_fl !== 6'b010000) begin n_bad++; $display("FAIL cmp_flags: got %b want 010000", o_fl); end
    n_cmp++; if (o_res !== 10'd0) begin n_bad++; $display("FAIL cmp_res: got %b want 0", o_res); end
    n_cmp++; if (o_ill !== 1'b0 || o_lat !== 4) begin n_bad++; $display("FAIL cmp_ill_lat: got ill=%b lat=%0d want 0/4", o_ill, o_lat); end
  endtask

  task automatic test_arbitration();
    int  n;
    logic exp;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_opa = 8'hF0; bus.req0_opb = 8'h3C; bus.req0_cmd = 4'd0; bus.req0_mode = 1'b0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_opa = 8'hF0; bus.req1_opb = 8'h3C; bus.req1_cmd = 4'd0; bus.req1_mode = 1'b0; bus.req1_cin = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = i[0];
      n = 0;
      while (bus.req0_ready !== 1'b1 && bus.req1_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      n_cmp++; if (bus.req0_ready !== ~exp || bus.req1_ready !== exp) begin
        n_bad++; $display("FAIL arb_grant_%0d: got rdy0=%b rdy1=%b want rdy%0d only", i, bus.req0_ready, bus.req1_ready, exp); end
      @(negedge clk);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp) begin
        n_bad++; $display("FAIL arb_rsp_id_%0d: got valid=%b id=%b want 1/%0d", i, bus.rsp_valid, bus.rsp_id, exp); end
      n_cmp++; if (bus.rsp_res !== 10'h030) begin n_bad++; $display("FAIL arb_rsp_res_%0d: got %h want 030", i, bus.rsp_res); end
      @(negedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    int   n;
    logic seen;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_opa = 8'd200; bus.req0_opb = 8'd100; bus.req0_cmd = 4'd0; bus.req0_mode = 1'b1; bus.req0_cin = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bus.req1_valid = 1'b1; bus.req1_opa = 8'd1; bus.req1_opb = 8'd2; bus.req1_cmd = 4'd0; bus.req1_mode = 1'b1; bus.req1_cin = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 10'd300 || bus.rsp_flags !== 6'b000001 || bus.rsp_id !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold_%0d: got valid=%b res=%0d flags=%b id=%b want 1/300/000001/0", k, bus.rsp_valid, bus.rsp_res, bus.rsp_flags, bus.rsp_id); end
      n_cmp++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_ready_%0d: got rdy0=%b rdy1=%b want 0/0", k, bus.req0_ready, bus.req1_ready); end
      @(negedge clk); #1;
    end
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got rsp_valid=%b want 0", bus.rsp_valid); end
    bus.req1_valid = 1'b1; bus.req1_opa = 8'd3; bus.req1_opb = 8'd4; bus.req1_cmd = 4'd9; bus.req1_mode = 1'b1; bus.req1_cin = 1'b0;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    n_cmp++; if (bus.alu_ce !== 1'b1 || bus.alu_inp_valid !== 2'b11) begin
      n_bad++; $display("FAIL rst_issue: got ce=%b iv=%b want 1/11", bus.alu_ce, bus.alu_inp_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_res !== 10'd0 || bus.rsp_id !== 1'b0) begin
      n_bad++; $display("FAIL midop_rsp: got valid=%b res=%0d id=%b want 0/0/0", bus.rsp_valid, bus.rsp_res, bus.rsp_id); end
    n_cmp++; if ({bus.alu_ce, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin} !== 25'd0) begin
      n_bad++; $display("FAIL midop_alu: got ce=%b iv=%b opa=%h opb=%h cmd=%h want all 0", bus.alu_ce, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.rsp_valid === 1'b1 || bus.alu_ce === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midop_dropped: got activity=%b want 0", seen); end
    bus.req0_valid = 1'b1; bus.req0_cmd = 4'd0; bus.req0_mode = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_cmd = 4'd0; bus.req1_mode = 1'b0;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_bad++; $display("FAIL midop_pointer: got rdy0=%b rdy1=%b want 1/0", bus.req0_ready, bus.req1_ready); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_opa = '0; bus.req0_opb = '0; bus.req0_cmd = '0; bus.req0_mode = 1'b0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_opa = '0; bus.req1_opb = '0; bus.req1_cmd = '0; bus.req1_mode = 1'b0; bus.req1_cin = 1'b0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_single_add();
    test_mul_latency();
    test_illegal();
    test_compare_zflags();
    test_arbitration();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
